// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle signed MULT/DIV sequencer.
package muldiv_pkg;

  localparam int MULDIV_W = 32;

  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} muldiv_state_t;

  typedef enum logic {OP_MULT, OP_DIV} muldiv_op_t;

endpackage

// File: rtl/neg_cond.sv
// Conditional two's-complement negation: out = neg ? -in : in.
module neg_cond #(
  parameter int W = 32
) (
  input  logic         neg_i,
  input  logic [W-1:0] in_i,
  output logic [W-1:0] out_o
);

  assign out_o = neg_i ? -in_i : in_i;

endmodule

// File: rtl/muldiv_seq.sv
// Signed MULT/DIV sequencer owning HI/LO: shift-add multiply and restoring
// divide on magnitudes, one iteration per cycle, signs applied in FIX.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CNT_W = $clog2(WIDTH);

  muldiv_state_t    state_q, state_d;
  muldiv_op_t       op_q, op_d;
  logic             signA_q, signA_d;
  logic             signB_q, signB_d;
  logic [WIDTH:0]   magA_q, magA_d;
  logic [WIDTH:0]   magB_q, magB_d;
  logic [WIDTH-1:0] work_hi_q, work_hi_d;
  logic [WIDTH-1:0] work_lo_q, work_lo_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             divZero_q, divZero_d;
  logic [WIDTH-1:0] hiOut_q, hiOut_d;
  logic [WIDTH-1:0] loOut_q, loOut_d;

  logic [WIDTH:0]     absA, absB;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quotFix, remFix;

  // Magnitudes are WIDTH+1 bits so the most negative operand stays exact.
  neg_cond #(.W(WIDTH + 1)) u_absA (
    .neg_i(A[WIDTH-1]), .in_i({A[WIDTH-1], A}), .out_o(absA)
  );
  neg_cond #(.W(WIDTH + 1)) u_absB (
    .neg_i(B[WIDTH-1]), .in_i({B[WIDTH-1], B}), .out_o(absB)
  );
  neg_cond #(.W(2 * WIDTH)) u_prod (
    .neg_i(signA_q ^ signB_q), .in_i({work_hi_q, work_lo_q}), .out_o(prodFix)
  );
  neg_cond #(.W(WIDTH)) u_quot (
    .neg_i(signA_q ^ signB_q), .in_i(work_lo_q), .out_o(quotFix)
  );
  neg_cond #(.W(WIDTH)) u_rem (
    .neg_i(signA_q), .in_i(work_hi_q), .out_o(remFix)
  );

  logic [WIDTH:0]   addend, mulSum, divShift;
  logic [WIDTH-1:0] divDiff;
  logic             divFits;

  // The RUN adder keeps its carry, which re-enters the product on the shift.
  assign addend   = work_lo_q[0] ? m_q : '0;
  assign mulSum   = {1'b0, work_hi_q} + addend;
  assign divShift = {work_hi_q, work_lo_q[WIDTH-1]};
  assign divFits  = (divShift >= m_q);
  assign divDiff  = divShift[WIDTH-1:0] - m_q[WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    signA_d   = signA_q;
    signB_d   = signB_q;
    magA_d    = magA_q;
    magB_d    = magB_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    divZero_d = divZero_q;
    hiOut_d   = hiOut_q;
    loOut_d   = loOut_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          op_d      = muldiv_op_t'(Op);
          signA_d   = A[WIDTH-1];
          signB_d   = B[WIDTH-1];
          magA_d    = absA;
          magB_d    = absB;
          divZero_d = 1'b0;
          state_d   = PREP;
        end
      end
      PREP: begin
        cnt_d     = '0;
        work_hi_d = '0;
        state_d   = RUN;
        if (op_q == OP_MULT) begin
          work_lo_d = magB_q[WIDTH-1:0];
          m_d       = magA_q;
        end else begin
          work_lo_d = magA_q[WIDTH-1:0];
          m_d       = magB_q;
          if (magB_q == '0) begin
            divZero_d = 1'b1;
            state_d   = DONE;
          end
        end
      end
      RUN: begin
        if (op_q == OP_MULT) begin
          work_hi_d = mulSum[WIDTH:1];
          work_lo_d = {mulSum[0], work_lo_q[WIDTH-1:1]};
        end else begin
          work_hi_d = divFits ? divDiff : divShift[WIDTH-1:0];
          work_lo_d = {work_lo_q[WIDTH-2:0], divFits};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (op_q == OP_MULT) begin
          {hiOut_d, loOut_d} = prodFix;
        end else begin
          hiOut_d = remFix;
          loOut_d = quotFix;
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      op_q      <= OP_MULT;
      signA_q   <= 1'b0;
      signB_q   <= 1'b0;
      magA_q    <= '0;
      magB_q    <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      divZero_q <= 1'b0;
      hiOut_q   <= '0;
      loOut_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      signA_q   <= signA_d;
      signB_q   <= signB_d;
      magA_q    <= magA_d;
      magB_q    <= magB_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      divZero_q <= divZero_d;
      hiOut_q   <= hiOut_d;
      loOut_q   <= loOut_d;
    end
  end

  assign Busy    = (state_q != IDLE);
  assign Done    = (state_q == DONE);
  assign DivZero = divZero_q;
  assign Hi      = hiOut_q;
  assign Lo      = loOut_q;

endmodule
